// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, memory operation kind
// and a helper that picks the D-cache operation.
// Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN (round-robin between caches).
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    COOLDOWN
  } arb_state_t;

  typedef enum logic [0:0] {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  // A write-through store must never be dropped, so a pending write wins over a read
  function automatic mem_op_t d_op_select(input logic write_request);
    return write_request ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/memory_arbiter_arb_select.sv
// Combinational winner selection between the I-cache and the D-cache.
// With MEMORY_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests go to the
// requester not served last; otherwise the D-cache always wins.
module arb_select (
  input  logic i_req,
  input  logic d_req,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  input  logic last_d,
`endif
  output logic grant_i,
  output logic grant_d
);

  // Pick at most one winner from the currently asserted requests
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant_d = ~last_d;
      grant_i = last_d;
    end else begin
      grant_d = d_req;
      grant_i = i_req;
    end
`else
    grant_d = d_req;
    grant_i = i_req & ~d_req;
`endif
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one external memory port between the I-cache (read only)
// and the D-cache (read / write-through). One transaction at a time; the
// winning request is latched at grant and the completion is routed back
// only to the granted cache.
// Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN (round-robin between caches).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read_request,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_response,
  output logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  d_read_request,
  input  logic                  d_write_request,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic                  d_response,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  memory_read_request,
  output logic                  memory_write_request,
  input  logic                  memory_response,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  busy
);

  arb_state_t state;
  mem_op_t    d_op;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic       last_d;
`endif

  assign d_req = d_read_request | d_write_request;
  assign d_op  = d_op_select(d_write_request);

  arb_select u_arb_select (
    .i_req   (i_read_request),
    .d_req   (d_req),
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    .last_d  (last_d),
`endif
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Sequence grant -> wait for memory -> one cooldown cycle, latching the winner's request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      memory_read_request  <= 1'b0;
      memory_write_request <= 1'b0;
      memory_addr          <= '0;
      memory_write_data    <= '0;
      busy                 <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_d               <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state                <= GRANT_D;
            memory_addr          <= d_addr;
            memory_write_data    <= d_write_data;
            memory_read_request  <= (d_op == OP_READ);
            memory_write_request <= (d_op == OP_WRITE);
            busy                 <= 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_d               <= 1'b1;
`endif
          end else if (grant_i) begin
            state                <= GRANT_I;
            memory_addr          <= i_addr;
            memory_write_data    <= '0;
            memory_read_request  <= 1'b1;
            memory_write_request <= 1'b0;
            busy                 <= 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_d               <= 1'b0;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (memory_response) begin
            state                <= COOLDOWN;
            memory_read_request  <= 1'b0;
            memory_write_request <= 1'b0;
          end
        end
        COOLDOWN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion is forwarded only to the granted cache and never while reset is applied
  assign i_response  = rst_n & (state == GRANT_I) & memory_response;
  assign d_response  = rst_n & (state == GRANT_D) & memory_response;
  assign i_read_data = memory_read_data;
  assign d_read_data = memory_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a memory model answers every memory
// request after a programmable latency, expected grants and responses are
// queued as stimulus is issued and popped by a monitor on the falling edge.
// Expected grant order follows MEMORY_ARBITER_ROUND_ROBIN_EN when defined.
module tb_memory_arbiter;

  typedef struct {
    logic        is_d;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read_request;
  logic [31:0] i_addr;
  logic        i_response;
  logic [31:0] i_read_data;
  logic        d_read_request;
  logic        d_write_request;
  logic [31:0] d_addr;
  logic [31:0] d_write_data;
  logic        d_response;
  logic [31:0] d_read_data;
  logic        memory_read_request;
  logic        memory_write_request;
  logic        memory_response;
  logic [31:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        busy;

  logic        model_response = 1'b0;
  logic        stale_response = 1'b0;
  logic        mem_enable = 1'b1;
  int          mem_latency = 2;
  logic        tb_last_d = 1'b0;
  logic        prev_req = 1'b0;

  txn_t        grant_q[$];
  txn_t        resp_q[$];
  int          total = 0;
  int          bad = 0;

  assign memory_response = model_response | stale_response;

  memory_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_read_request       (i_read_request),
    .i_addr               (i_addr),
    .i_response           (i_response),
    .i_read_data          (i_read_data),
    .d_read_request       (d_read_request),
    .d_write_request      (d_write_request),
    .d_addr               (d_addr),
    .d_write_data         (d_write_data),
    .d_response           (d_response),
    .d_read_data          (d_read_data),
    .memory_read_request  (memory_read_request),
    .memory_write_request (memory_write_request),
    .memory_response      (memory_response),
    .memory_addr          (memory_addr),
    .memory_write_data    (memory_write_data),
    .memory_read_data     (memory_read_data),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] memValue(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic pushTxn(input txn_t t);
    grant_q.push_back(t);
    resp_q.push_back(t);
    tb_last_d = t.is_d;
  endtask

  function automatic txn_t mkTxn(input logic is_d, input logic is_write, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.is_d     = is_d;
    t.is_write = is_write;
    t.addr     = addr;
    t.wdata    = wdata;
    t.rdata    = memValue(addr);
    return t;
  endfunction

  // Requester model: assert, wait for the pulse, hold one extra cycle, then drop
  task automatic applyStimulus(input logic is_d, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    if (is_d) begin
      d_read_request  = rd;
      d_write_request = wr;
      d_addr          = addr;
      d_write_data    = wdata;
    end else begin
      i_read_request = 1'b1;
      i_addr         = addr;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_response : i_response) && n < 200);
    if (!(is_d ? d_response : i_response))
      checkOutput(is_d ? "d_timeout" : "i_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (is_d) begin
      d_read_request  = 1'b0;
      d_write_request = 1'b0;
    end else begin
      i_read_request = 1'b0;
    end
  endtask

  // Memory model: answer each new memory request after mem_latency cycles
  initial begin
    logic [31:0] captured;
    memory_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_enable && rst_n && (memory_read_request || memory_write_request)) begin
        captured = memory_addr;
        repeat (mem_latency - 1) @(negedge clk);
        @(posedge clk); #1;
        model_response   = 1'b1;
        memory_read_data = memValue(captured);
        @(posedge clk); #1;
        model_response   = 1'b0;
        memory_read_data = $urandom;
      end
    end
  end

  // Monitor: pop expected grants on request rise and expected responses on pulses
  initial begin
    txn_t g;
    txn_t r;
    forever begin
      @(negedge clk);
      if ((memory_read_request || memory_write_request) && !prev_req) begin
        if (grant_q.size() == 0) begin
          checkOutput("grant_unexpected", 32'd1, 32'd0);
        end else begin
          g = grant_q.pop_front();
          checkOutput("grant_addr", memory_addr, g.addr);
          checkOutput("grant_rd", {31'd0, memory_read_request}, {31'd0, ~g.is_write});
          checkOutput("grant_wr", {31'd0, memory_write_request}, {31'd0, g.is_write});
          if (g.is_write)
            checkOutput("grant_wdata", memory_write_data, g.wdata);
          checkOutput("grant_busy", {31'd0, busy}, 32'd1);
        end
      end
      prev_req = memory_read_request || memory_write_request;
      if (i_response || d_response) begin
        if (resp_q.size() == 0) begin
          checkOutput("resp_unexpected", {30'd0, i_response, d_response}, 32'd0);
        end else begin
          r = resp_q.pop_front();
          checkOutput("resp_i", {31'd0, i_response}, {31'd0, ~r.is_d});
          checkOutput("resp_d", {31'd0, d_response}, {31'd0, r.is_d});
          checkOutput("resp_data", r.is_d ? d_read_data : i_read_data, r.rdata);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    logic d_first;
    rst_n           = 1'b0;
    i_read_request  = 1'b0;
    i_addr          = 32'h0;
    d_read_request  = 1'b0;
    d_write_request = 1'b0;
    d_addr          = 32'h0;
    d_write_data    = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_rd", {31'd0, memory_read_request}, 32'd0);
    checkOutput("rst_mem_wr", {31'd0, memory_write_request}, 32'd0);
    checkOutput("rst_addr", memory_addr, 32'd0);
    checkOutput("rst_wdata", memory_write_data, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_resp", {30'd0, i_response, d_response}, 32'd0);
    rst_n = 1'b1;

    // I-cache only, memory latency 2, latency and busy timing
    mem_latency = 2;
    @(posedge clk); #1;
    pushTxn(mkTxn(1'b0, 1'b0, 32'h0000_0100, 32'h0));
    i_read_request = 1'b1;
    i_addr         = 32'h0000_0100;
    @(negedge clk);
    checkOutput("t1_no_early_grant", {31'd0, memory_read_request}, 32'd0);
    @(negedge clk);
    checkOutput("t1_grant_next_cycle", {31'd0, memory_read_request}, 32'd1);
    n = 0;
    while (!i_response && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t1_resp_delay", n, 32'd2);
    checkOutput("t1_d_quiet", {31'd0, d_response}, 32'd0);
    @(negedge clk);
    checkOutput("t1_busy_cooldown", {31'd0, busy}, 32'd1);
    checkOutput("t1_req_released", {31'd0, memory_read_request}, 32'd0);
    @(posedge clk); #1;
    i_read_request = 1'b0;
    @(negedge clk);
    checkOutput("t1_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("t1_no_regrant", {31'd0, memory_read_request}, 32'd0);

    // Simultaneous I and D reads, three rounds
    mem_latency = 1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      d_first = ~tb_last_d;
`else
      d_first = 1'b1;
`endif
      if (d_first) begin
        pushTxn(mkTxn(1'b1, 1'b0, 32'h0000_0200, 32'h0));
        pushTxn(mkTxn(1'b0, 1'b0, 32'h0000_0100, 32'h0));
      end else begin
        pushTxn(mkTxn(1'b0, 1'b0, 32'h0000_0100, 32'h0));
        pushTxn(mkTxn(1'b1, 1'b0, 32'h0000_0200, 32'h0));
      end
      fork
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
      join
    end

    // D issues back-to-back requests while I waits
    mem_latency = 2;
    @(posedge clk); #1;
    pushTxn(mkTxn(1'b1, 1'b0, 32'h0000_0400, 32'h0));
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    pushTxn(mkTxn(1'b0, 1'b0, 32'h0000_0104, 32'h0));
    pushTxn(mkTxn(1'b1, 1'b0, 32'h0000_0408, 32'h0));
`else
    pushTxn(mkTxn(1'b1, 1'b0, 32'h0000_0408, 32'h0));
    pushTxn(mkTxn(1'b0, 1'b0, 32'h0000_0104, 32'h0));
`endif
    fork
      begin
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0408, 32'h0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
    join

    // D-cache write, latency 3
    mem_latency = 3;
    @(posedge clk); #1;
    pushTxn(mkTxn(1'b1, 1'b1, 32'h2000_0004, 32'h1234_5678));
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h2000_0004, 32'h1234_5678);

    // D read and write together: the write must win
    mem_latency = 2;
    @(posedge clk); #1;
    pushTxn(mkTxn(1'b1, 1'b1, 32'h3000_0008, 32'hCAFE_F00D));
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0008, 32'hCAFE_F00D);

    // Reset during GRANT_D followed by a stale memory response
    mem_enable = 1'b0;
    @(posedge clk); #1;
    grant_q.push_back(mkTxn(1'b1, 1'b0, 32'h0000_0500, 32'h0));
    d_read_request = 1'b1;
    d_addr         = 32'h0000_0500;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!memory_read_request && n < 20);
    checkOutput("t6_granted", {31'd0, memory_read_request}, 32'd1);
    @(posedge clk); #1;
    rst_n          = 1'b0;
    d_read_request = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_rst_mem_rd", {31'd0, memory_read_request}, 32'd0);
    checkOutput("t6_rst_addr", memory_addr, 32'd0);
    checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst_n          = 1'b1;
    stale_response = 1'b1;
    @(negedge clk);
    checkOutput("t6_stale_d_resp", {31'd0, d_response}, 32'd0);
    checkOutput("t6_stale_i_resp", {31'd0, i_response}, 32'd0);
    @(posedge clk); #1;
    stale_response = 1'b0;
    @(negedge clk);
    checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_idle_mem_rd", {31'd0, memory_read_request}, 32'd0);
    mem_enable = 1'b1;
    @(posedge clk); #1;
    pushTxn(mkTxn(1'b1, 1'b0, 32'h0000_0600, 32'h0));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("end_grant_q_empty", grant_q.size(), 32'd0);
    checkOutput("end_resp_q_empty", resp_q.size(), 32'd0);
    checkOutput("end_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
